// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle 8-bit CPU controller: states,
// opcodes, instruction field positions and the decoded-instruction struct.
package cpu_pkg;

  typedef logic [2:0] state_t;
  localparam state_t ST_FETCH  = 3'd0;
  localparam state_t ST_DECODE = 3'd1;
  localparam state_t ST_EXEC   = 3'd2;
  localparam state_t ST_WB     = 3'd3;
  localparam state_t ST_HALT   = 3'd4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SHL = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  localparam logic [2:0] CTL_LDI  = 3'b000;
  localparam logic [2:0] CTL_JMP  = 3'b001;
  localparam logic [2:0] CTL_JZ   = 3'b010;
  localparam logic [2:0] CTL_JC   = 3'b011;
  localparam logic [2:0] CTL_HALT = 3'b100;

  localparam int IR_CTL = 15;
  localparam int OP_HI  = 14;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 10;
  localparam int RA_HI  = 9;
  localparam int RA_LO  = 8;
  localparam int RB_HI  = 7;
  localparam int RB_LO  = 6;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  typedef struct packed {
    logic       is_alu;
    logic       is_ldi;
    logic       is_jmp;
    logic       is_jz;
    logic       is_jc;
    logic       is_halt;
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [7:0] imm;
  } dec_t;

endpackage

// File: rtl/cpu_decode.sv
// Pure combinational field decode of the instruction register.
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output dec_t        dec
);

  always_comb begin
    dec         = '0;
    dec.op      = ir[OP_HI:OP_LO];
    dec.rd      = ir[RD_HI:RD_LO];
    dec.ra      = ir[RA_HI:RA_LO];
    dec.rb      = ir[RB_HI:RB_LO];
    dec.imm     = ir[IMM_HI:IMM_LO];
    dec.is_alu  = ~ir[IR_CTL];
    // Control sub-ops 101..111 fall through as NOPs
    dec.is_ldi  = ir[IR_CTL] && (dec.op == CTL_LDI);
    dec.is_jmp  = ir[IR_CTL] && (dec.op == CTL_JMP);
    dec.is_jz   = ir[IR_CTL] && (dec.op == CTL_JZ);
    dec.is_jc   = ir[IR_CTL] && (dec.op == CTL_JC);
    dec.is_halt = ir[IR_CTL] && (dec.op == CTL_HALT);
  end

endmodule

// File: rtl/cpu_control.sv
// Fetch/decode/execute/writeback controller: owns pc, ir, result and the
// zero/carry flags, and sequences instruction memory, register file and ALU.
module cpu_control
  import cpu_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_rd_en,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               imem_valid,
  output logic [1:0]         rf_rd_addr_a,
  output logic [1:0]         rf_rd_addr_b,
  output logic               rf_wr_en,
  output logic [1:0]         rf_wr_addr,
  output logic [7:0]         rf_wr_data,
  output logic [2:0]         alu_opcode,
  input  logic [7:0]         alu_out,
  input  logic               alu_zero,
  input  logic               alu_carry,
  output logic               zero_flag,
  output logic               carry_flag,
  output logic               halted
);

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic [INSTR_W-1:0] ir;
  logic [7:0]        result;
  logic              take_q;
  logic [PC_W-1:0]   target_q;
  dec_t              dec;
  logic [PC_W-1:0]   target;

  cpu_decode u_dec (
    .ir  (ir),
    .dec (dec)
  );

  assign target = PC_W'(dec.imm);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_FETCH;
      pc         <= '0;
      ir         <= '0;
      result     <= '0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
      take_q     <= 1'b0;
      target_q   <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (run && imem_valid) begin
            ir    <= imem_data;
            state <= ST_DECODE;
          end
        end
        ST_DECODE: state <= ST_EXEC;
        ST_EXEC: begin
          if (dec.is_alu) begin
            result    <= alu_out;
            zero_flag <= alu_zero;
            // Carry is only defined by the ALU for add/sub
            if (dec.op == OP_ADD || dec.op == OP_SUB)
              carry_flag <= alu_carry;
          end else if (dec.is_ldi) begin
            result <= dec.imm;
          end
          take_q   <= dec.is_jmp || (dec.is_jz && zero_flag) || (dec.is_jc && carry_flag);
          target_q <= target;
          state    <= dec.is_halt ? ST_HALT : ST_WB;
        end
        ST_WB: begin
          pc    <= take_q ? target_q : pc + PC_W'(1);
          state <= ST_FETCH;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_FETCH;
      endcase
    end
  end

  // Gating with rst_n keeps a reset that lands on writeback from committing
  assign imem_addr    = pc;
  assign imem_rd_en   = rst_n && (state == ST_FETCH) && run;
  assign rf_wr_en     = rst_n && (state == ST_WB) && (dec.is_alu || dec.is_ldi);
  assign rf_wr_addr   = dec.rd;
  assign rf_wr_data   = result;
  assign rf_rd_addr_a = dec.ra;
  assign rf_rd_addr_b = dec.rb;
  assign alu_opcode   = dec.op;
  assign halted       = (state == ST_HALT);

endmodule

// File: tb/tb_cpu_control.sv
// Directed bench for cpu_control with a behavioural register file, ALU and
// instruction memory around the controller.
module tb_cpu_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [7:0]  imem_addr;
  logic        imem_rd_en;
  logic [15:0] imem_data;
  logic        imem_valid;
  logic [1:0]  rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr;
  logic        rf_wr_en;
  logic [7:0]  rf_wr_data;
  logic [2:0]  alu_opcode;
  logic [7:0]  alu_out;
  logic        alu_zero, alu_carry;
  logic        zero_flag, carry_flag, halted;

  logic [15:0] mem [256];
  logic [7:0]  rf [4];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  cpu_control #(.PC_W(8), .INSTR_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .imem_addr    (imem_addr),
    .imem_rd_en   (imem_rd_en),
    .imem_data    (imem_data),
    .imem_valid   (imem_valid),
    .rf_rd_addr_a (rf_rd_addr_a),
    .rf_rd_addr_b (rf_rd_addr_b),
    .rf_wr_en     (rf_wr_en),
    .rf_wr_addr   (rf_wr_addr),
    .rf_wr_data   (rf_wr_data),
    .alu_opcode   (alu_opcode),
    .alu_out      (alu_out),
    .alu_zero     (alu_zero),
    .alu_carry    (alu_carry),
    .zero_flag    (zero_flag),
    .carry_flag   (carry_flag),
    .halted       (halted)
  );

  assign imem_data = mem[imem_addr];

  // ALU model: carry forced low for non add/sub so a stray carry update shows
  always_comb begin
    logic [8:0] w;
    logic [7:0] a, b;
    a = rf[rf_rd_addr_a];
    b = rf[rf_rd_addr_b];
    w = '0;
    case (alu_opcode)
      3'b000: w = {1'b0, a} + {1'b0, b};
      3'b001: w = {1'b0, a} - {1'b0, b};
      3'b010: w = {1'b0, a[6:0], 1'b0};
      3'b011: w = {1'b0, a[0], a[7:1]};
      3'b100: w = {1'b0, a & b};
      3'b101: w = {1'b0, a | b};
      3'b110: w = {1'b0, a ^ b};
      default: w = {1'b0, ~a};
    endcase
    alu_out   = w[7:0];
    alu_carry = w[8];
    alu_zero  = (w[7:0] == 8'h00);
  end

  always @(posedge clk) if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hD000;
    for (int i = 0; i < 4; i++) rf[i] = 8'h00;
    mem[8'h00] = 16'h840F;  // LDI r1,0x0F
    mem[8'h01] = 16'h88F1;  // LDI r2,0xF1
    mem[8'h02] = 16'h0D80;  // ADD r3,r1,r2
    mem[8'h03] = 16'h800A;  // LDI r0,0x0A
    mem[8'h04] = 16'h6040;  // XOR r0,r0,r1 -> 0x05
    mem[8'h05] = 16'hA020;  // JZ 0x20 (not taken)
    mem[8'h06] = 16'h6D40;  // XOR r3,r1,r1 -> 0x00
    mem[8'h07] = 16'hA020;  // JZ 0x20 (taken)
    mem[8'h20] = 16'h90FF;  // JMP 0xFF
    mem[8'hFF] = 16'hD000;  // NOP, pc wraps

    rst_n = 1'b0; run = 1'b0; imem_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_addr",  imem_addr, 0);
    chk("rst_rden",  imem_rd_en, 0);
    chk("rst_wren",  rf_wr_en, 0);
    chk("rst_flags", {zero_flag, carry_flag}, 0);
    chk("rst_halt",  halted, 0);
    chk("rst_op",    {alu_opcode, rf_rd_addr_a, rf_rd_addr_b, rf_wr_data}, 0);

    // Cycle k is the interval after the k-th negedge following reset release
    @(negedge clk);
    rst_n = 1'b1; run = 1'b1; imem_valid = 1'b1;
    #1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc > 0) tick();
      case (cyc)
        0:  chk("c0_rden", {imem_rd_en, imem_addr}, {1'b1, 8'h00});
        1:  chk("c1_rden", imem_rd_en, 0);
        3:  chk("ldi_r1", {rf_wr_en, rf_wr_addr, rf_wr_data}, {1'b1, 2'd1, 8'h0F});
        7:  chk("ldi_r2", {rf_wr_en, rf_wr_addr, rf_wr_data}, {1'b1, 2'd2, 8'hF1});
        10: chk("add_wren_early", rf_wr_en, 0);
        11: begin
          chk("add_r3",    {rf_wr_en, rf_wr_addr, rf_wr_data}, {1'b1, 2'd3, 8'h00});
          chk("add_flags", {zero_flag, carry_flag}, 2'b11);
        end
        12: chk("12cyc_fetch", {imem_rd_en, imem_addr}, {1'b1, 8'h03});
        15: chk("ldi_r0", {rf_wr_en, rf_wr_addr, rf_wr_data}, {1'b1, 2'd0, 8'h0A});
        19: begin
          chk("xor_wr",    {rf_wr_en, rf_wr_addr, rf_wr_data}, {1'b1, 2'd0, 8'h05});
          chk("xor_flags", {zero_flag, carry_flag}, 2'b01);
        end
        23: chk("jz_nt_wren", rf_wr_en, 0);
        24: chk("jz_nt_pc", imem_addr, 8'h06);
        27: chk("xor0_flags", {zero_flag, carry_flag}, 2'b11);
        31: chk("jz_t_wren", rf_wr_en, 0);
        32: chk("jz_t_pc", imem_addr, 8'h20);
        36: chk("jmp_pc", imem_addr, 8'hFF);
        39: chk("nop_wren", rf_wr_en, 0);
        default: ;
      endcase
    end

    // pc wrap, then run=0 stalls with no fetch request
    @(negedge clk);
    run = 1'b0;
    #1;
    chk("wrap_pc", imem_addr, 8'h00);
    chk("run0_rden", imem_rd_en, 0);
    tick(); tick();
    chk("run0_stall", {imem_rd_en, imem_addr, rf_wr_en}, 0);

    // Memory wait: valid low for 3 fetch cycles, HALT arrives on the 4th
    mem[8'h00] = 16'hC000;
    @(negedge clk);
    run = 1'b1; imem_valid = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("wait_rden", imem_rd_en, 1);
      tick();
    end
    imem_valid = 1'b1;
    #1;
    chk("wait_rden4", imem_rd_en, 1);
    tick();
    chk("wait_loaded", {imem_rd_en, halted}, 0);
    tick(); tick();
    chk("halt_on", halted, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      run = i[0];
      #1;
      chk("halt_hold", {halted, imem_rd_en, rf_wr_en}, {1'b1, 1'b0, 1'b0});
    end

    // Reset during writeback of an ADD suppresses the write
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; run = 1'b1; imem_valid = 1'b1;
    mem[8'h00] = 16'h0D80;
    rf[3] = 8'h77;
    #1;
    tick(); tick(); tick();
    chk("wb_flags_set", {zero_flag, carry_flag}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk("rst_wb_wren", rf_wr_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_wb_state", {imem_rd_en, imem_addr, halted}, {1'b1, 8'h00, 1'b0});
    chk("rst_wb_flags", {zero_flag, carry_flag}, 0);
    chk("rst_wb_rf3", rf[3], 8'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_control.md
Name: cpu_control

Overview:
- Multi-cycle fetch/decode/execute controller for the 8-bit datapath; drives the ALU (opcode, register read addresses), consumes its result/zero/carry, and writes results back to a 4-entry register file.
- Sits between instruction memory, register file and ALU; owns PC, instruction register and the zero/carry flags.
- Each instruction takes 4 cycles, plus any cycles spent waiting for instruction memory.

Parameters:
PC_W, 8, program counter / instruction address width
INSTR_W, 16, instruction word width (fixed format below; only 16 supported)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
run  input  1  enables fetching; sampled only in FETCH
imem_addr  output  PC_W  instruction address (= pc)
imem_rd_en  output  1  instruction read request
imem_data  input  INSTR_W  instruction word
imem_valid  input  1  imem_data valid this cycle
rf_rd_addr_a  output  2  register read address A (ALU operand A)
rf_rd_addr_b  output  2  register read address B (ALU operand B)
rf_wr_en  output  1  register write strobe
rf_wr_addr  output  2  register write address
rf_wr_data  output  8  register write data
alu_opcode  output  3  ALU operation select
alu_out  input  8  ALU result (combinational)
alu_zero  input  1  ALU zero (combinational)
alu_carry  input  1  ALU carry; meaningful only for opcodes 000 (add) and 001 (sub)
zero_flag  output  1  latched zero flag
carry_flag  output  1  latched carry flag
halted  output  1  high in HALT state

Behaviour:
- Reset (rst_n=0 at a clock edge, any state):
  - state=FETCH, pc=0, ir=0, result=0, flags=0.
  - All outputs 0 except imem_addr=0.
  - A reset arriving mid-instruction aborts it; no write is issued.
- Instruction format:
  - ir[15]=0: ALU op. alu_opcode=ir[14:12], rd=ir[11:10], ra=ir[9:8], rb=ir[7:6].
  - ir[15]=1: control op, with sub=ir[14:12]:
    - 000 LDI rd,imm8 (imm=ir[7:0])
    - 001 JMP imm
    - 010 JZ imm (jump if zero_flag)
    - 011 JC imm (jump if carry_flag)
    - 100 HALT
    - 101-111 NOP
- rf_rd_addr_a=ir[9:8], rf_rd_addr_b=ir[7:6], alu_opcode=ir[14:12]: all driven combinationally from ir in every state.
- FETCH:
  - If run=1: imem_rd_en=1 and imem_addr=pc.
  - If run=1 and imem_valid=1 in the same cycle: ir<=imem_data, go to DECODE.
  - Otherwise stay in FETCH. imem_valid is ignored when run=0.
- DECODE: one cycle so register-file reads settle; go to EXEC.
- EXEC:
  - ALU op: result<=alu_out; zero_flag<=alu_zero.
    - carry_flag<=alu_carry only if alu_opcode is 000 or 001; otherwise carry_flag holds.
  - LDI: result<=ir[7:0]; flags unchanged.
  - Branches: branch condition and target are latched.
  - HALT: go to HALT.
  - Go to WRITEBACK for all non-HALT instructions.
- WRITEBACK:
  - rf_wr_en=1 for exactly this one cycle, only for ALU op or LDI.
  - rf_wr_addr=ir[11:10], rf_wr_data=result.
  - pc<=target if the jump is taken, else pc<=pc+1.
  - Go to FETCH.
- HALT: halted=1; no fetch or write. Only reset leaves HALT; run is ignored.
- pc wraps modulo 2^PC_W: increment from 2^PC_W-1 gives 0.
- Jump target is ir[7:0] zero-extended or truncated to PC_W.
- rf_wr_en is never asserted outside WRITEBACK.
- Flags are updated only in EXEC, and only as stated above.
- Minimum throughput: 4 cycles per instruction when imem_valid is returned in the first FETCH cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - state enum: FETCH, DECODE, EXEC, WRITEBACK, HALT
  - ALU opcode constants: ADD=000, SUB=001, SHL=010, ROR=011, AND=100, OR=101, XOR=110, NOT=111
  - control sub-op constants: LDI, JMP, JZ, JC, HALT
  - instruction field bit positions
- Sub-module cpu_decode: combinational ir -> field decode (is_alu, is_ldi, is_jmp/jz/jc, is_halt, rd, ra, rb, imm).
- FSM, pc and flags stay in cpu_control.

Test Plan:
- LDI r1,0x0F then LDI r2,0xF1 then ADD r3,r1,r2 (imem_valid same cycle as rd_en):
  - Writes r1=0x0F, then r2=0xF1, then r3=0x00.
  - After the ADD: zero_flag=1, carry_flag=1; exactly 12 cycles from first FETCH.
- With carry_flag=1, execute XOR (op 110) giving 0x05: zero_flag=0, carry_flag stays 1, rf_wr_data=0x05.
- JZ 0x20 with zero_flag=1 -> next imem_addr=0x20, no rf_wr_en. JZ 0x20 with zero_flag=0 -> pc+1.
- PC wrap: pc=0xFF executing NOP -> next imem_addr=0x00.
- imem_valid held low for 3 FETCH cycles, then high -> imem_rd_en high all 4 cycles, ir loads on the 4th. Separately, run=0 -> imem_rd_en=0 and no progress.
- HALT -> halted=1 indefinitely regardless of run.
- Separately, rst_n=0 during WRITEBACK of an ADD -> rf_wr_en=0 on that edge; next cycle state=FETCH, pc=0, flags=0.
